// File: rtl/calc_sum_display.sv
// calc_sum_display: captures opA+opB on a rising somar edge, converts the
// sum to BCD by repeated subtraction and scans it onto a 2-digit 7-seg.
// Ports:
//   CLK, reset (async, active-high), somar (sum request), opA/opB (4-bit)
//   result (5-bit sum), valid (conversion complete)
//   seg {g,f,e,d,c,b,a} and an {tens,units}, polarity set by ACTIVE_LOW
module calc_sum_display #(
    parameter int REFRESH_DIV = 50000,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       somar,
    input  logic [3:0] opA,
    input  logic [3:0] opB,
    output logic [4:0] result,
    output logic       valid,
    output logic [6:0] seg,
    output logic [1:0] an
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
    localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [1:0] AN_OFF  = ACTIVE_LOW ? 2'b11 : 2'b00;

    typedef enum logic {S_IDLE, S_CONV} state_t;

    state_t        r_state, w_state_nxt;
    logic          r_somar_d;
    logic [4:0]    r_work, w_work_nxt;
    logic [1:0]    r_tens_acc, w_tens_acc_nxt;
    logic [3:0]    r_units, w_units_nxt;
    logic [3:0]    r_tens, w_tens_nxt;
    logic [4:0]    r_result, w_result_nxt;
    logic          r_valid, w_valid_nxt;
    logic          r_have_data, w_have_data_nxt;
    logic [CW-1:0] r_refresh_cnt;
    logic          r_digit_sel;
    logic [6:0]    r_seg;
    logic [1:0]    r_an;

    logic          w_capture;
    logic [6:0]    w_digit_seg;
    logic [1:0]    w_an_raw;

    function automatic logic [6:0] f_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    assign w_capture = somar && !r_somar_d;

    always_comb begin
        w_state_nxt     = r_state;
        w_work_nxt      = r_work;
        w_tens_acc_nxt  = r_tens_acc;
        w_units_nxt     = r_units;
        w_tens_nxt      = r_tens;
        w_result_nxt    = r_result;
        w_valid_nxt     = r_valid;
        w_have_data_nxt = r_have_data;
        unique case (r_state)
            S_IDLE: begin
                if (w_capture) begin
                    w_work_nxt     = {1'b0, opA} + {1'b0, opB};
                    w_tens_acc_nxt = 2'd0;
                    w_valid_nxt    = 1'b0;
                    w_state_nxt    = S_CONV;
                end
            end
            S_CONV: begin
                if (r_work >= 5'd10) begin
                    w_work_nxt     = r_work - 5'd10;
                    w_tens_acc_nxt = r_tens_acc + 2'd1;
                end else begin
                    w_units_nxt     = r_work[3:0];
                    w_tens_nxt      = {2'b00, r_tens_acc};
                    w_result_nxt    = (5'(r_tens_acc) * 5'd10) + r_work;
                    w_valid_nxt     = 1'b1;
                    w_have_data_nxt = 1'b1;
                    w_state_nxt     = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_somar_d   <= 1'b0;
            r_work      <= 5'd0;
            r_tens_acc  <= 2'd0;
            r_units     <= 4'd0;
            r_tens      <= 4'd0;
            r_result    <= 5'd0;
            r_valid     <= 1'b0;
            r_have_data <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_somar_d   <= somar;
            r_work      <= w_work_nxt;
            r_tens_acc  <= w_tens_acc_nxt;
            r_units     <= w_units_nxt;
            r_tens      <= w_tens_nxt;
            r_result    <= w_result_nxt;
            r_valid     <= w_valid_nxt;
            r_have_data <= w_have_data_nxt;
        end
    end

    // Tens digit is blanked for a leading zero; all blank before any data.
    always_comb begin
        w_digit_seg = 7'h00;
        if (r_have_data) begin
            if (!r_digit_sel)
                w_digit_seg = f_seg(r_units);
            else if (r_tens != 4'd0)
                w_digit_seg = f_seg(r_tens);
        end
        w_an_raw = r_digit_sel ? 2'b10 : 2'b01;
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_refresh_cnt <= '0;
            r_digit_sel   <= 1'b0;
            r_seg         <= SEG_OFF;
            r_an          <= AN_OFF;
        end else begin
            if (r_refresh_cnt == CNT_MAX) begin
                r_refresh_cnt <= '0;
                r_digit_sel   <= ~r_digit_sel;
            end else begin
                r_refresh_cnt <= r_refresh_cnt + 1'b1;
            end
            r_seg <= ACTIVE_LOW ? ~w_digit_seg : w_digit_seg;
            r_an  <= ACTIVE_LOW ? ~w_an_raw : w_an_raw;
        end
    end

    assign result = r_result;
    assign valid  = r_valid;
    assign seg    = r_seg;
    assign an     = r_an;

endmodule

// File: tb/tb_calc_sum_display.sv
// Randomized self-checking bench for calc_sum_display (REFRESH_DIV=4,
// ACTIVE_LOW=1); expected values come from decimal arithmetic on the sum.
module tb_calc_sum_display;

    localparam int RDIV = 4;

    logic       CLK = 1'b0;
    logic       reset;
    logic       somar;
    logic [3:0] opA;
    logic [3:0] opB;
    logic [4:0] result;
    logic       valid;
    logic [6:0] seg;
    logic [1:0] an;

    int n_vec = 0;
    int n_err = 0;

    logic [6:0] codes [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    calc_sum_display #(.REFRESH_DIV(RDIV), .ACTIVE_LOW(1'b1)) dut (
        .CLK(CLK), .reset(reset), .somar(somar),
        .opA(opA), .opB(opB),
        .result(result), .valid(valid),
        .seg(seg), .an(an)
    );

    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    // Pin-level code for a digit (active-low), or blank.
    function automatic logic [6:0] pin_code(input int d, input bit blank);
        logic [6:0] c;
        c = blank ? 7'h7F : ~codes[d];
        return c;
    endfunction

    task automatic check_display(input int s, input string name);
        bit seen_u = 0;
        bit seen_t = 0;
        logic [6:0] exp_seg;
        tick;
        for (int i = 0; i < 2*RDIV + 2; i++) begin
            n_vec++;
            if (an === 2'b10) begin
                seen_u = 1;
                exp_seg = pin_code(s % 10, 1'b0);
                if (seg !== exp_seg) begin
                    n_err++;
                    $display("FAIL %s units seg: got %h want %h", name, seg, exp_seg);
                end
            end else if (an === 2'b01) begin
                seen_t = 1;
                exp_seg = pin_code(s / 10, (s / 10) == 0);
                if (seg !== exp_seg) begin
                    n_err++;
                    $display("FAIL %s tens seg: got %h want %h", name, seg, exp_seg);
                end
            end else begin
                n_err++;
                $display("FAIL %s an onehot: got %b want 10 or 01", name, an);
            end
            tick;
        end
        n_vec++;
        if (!(seen_u && seen_t)) begin
            n_err++;
            $display("FAIL %s scan coverage: got u=%0d t=%0d want 1 1",
                     name, seen_u, seen_t);
        end
    endtask

    task automatic do_sum(input logic [3:0] a, input logic [3:0] b,
                          input string name, input bit chk_disp);
        int s;
        int lat;
        s = int'(a) + int'(b);
        lat = s / 10 + 1;
        opA = a;
        opB = b;
        somar = 1'b1;
        tick;
        somar = 1'b0;
        n_vec++;
        if (valid !== 1'b0) begin
            n_err++;
            $display("FAIL %s valid after capture: got %b want 0", name, valid);
        end
        for (int i = 1; i < lat; i++) begin
            tick;
            n_vec++;
            if (valid !== 1'b0) begin
                n_err++;
                $display("FAIL %s valid early cyc %0d: got %b want 0", name, i, valid);
            end
        end
        tick;
        n_vec++;
        if (valid !== 1'b1 || result !== 5'(s)) begin
            n_err++;
            $display("FAIL %s result: got v=%b r=%0d want v=1 r=%0d",
                     name, valid, result, s);
        end
        if (chk_disp)
            check_display(s, name);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        somar = 1'b0;
        opA = 4'd0;
        opB = 4'd0;
        tick;
        reset = 1'b0;
        repeat (6) tick;
        // Asynchronous assertion mid-scan.
        reset = 1'b1;
        #1;
        n_vec++;
        if (seg !== 7'h7F || an !== 2'b11 || result !== 5'd0 || valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_async: got seg=%h an=%b r=%0d v=%b want 7f 11 0 0",
                     seg, an, result, valid);
        end
        tick;
        reset = 1'b0;
        tick;
        n_vec++;
        if (an !== 2'b10 || seg !== 7'h7F) begin
            n_err++;
            $display("FAIL reset_first: got an=%b seg=%h want 10 7f", an, seg);
        end
        for (int i = 0; i < 2*RDIV; i++) begin
            tick;
            n_vec++;
            if (seg !== 7'h7F) begin
                n_err++;
                $display("FAIL reset_blank: got %h want 7f", seg);
            end
        end
    endtask

    task automatic test_scan;
        logic [1:0] prev;
        int k;
        prev = an;
        k = 0;
        while (an === prev && k < 2*RDIV) begin
            tick;
            k++;
        end
        n_vec++;
        if (an === prev) begin
            n_err++;
            $display("FAIL scan_start: got an=%b stuck want toggle", an);
        end
        for (int r = 0; r < 3; r++) begin
            prev = an;
            for (int j = 1; j < RDIV; j++) begin
                tick;
                n_vec++;
                if (an !== prev) begin
                    n_err++;
                    $display("FAIL scan_hold: got %b want %b", an, prev);
                end
            end
            tick;
            n_vec++;
            if (an !== ~prev) begin
                n_err++;
                $display("FAIL scan_flip: got %b want %b", an, ~prev);
            end
        end
    endtask

    task automatic test_directed;
        do_sum(4'd3, 4'd4, "sum_3_4", 1'b1);
        do_sum(4'd15, 4'd15, "sum_15_15", 1'b1);
        do_sum(4'd9, 4'd1, "sum_9_1", 1'b1);
    endtask

    task automatic test_ignore_in_conv;
        opA = 4'd8;
        opB = 4'd8;
        somar = 1'b1;
        tick;
        somar = 1'b0;
        tick;
        opA = 4'd1;
        opB = 4'd1;
        somar = 1'b1;
        tick;
        somar = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (valid !== 1'b1 || result !== 5'd16) begin
                n_err++;
                $display("FAIL conv_drop cyc %0d: got v=%b r=%0d want 1 16",
                         i, valid, result);
            end
            tick;
        end
    endtask

    task automatic test_held_level;
        int lows = 0;
        opA = 4'd2;
        opB = 4'd3;
        somar = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick;
            if (valid === 1'b0)
                lows++;
        end
        somar = 1'b0;
        tick;
        n_vec++;
        if (lows != 1 || result !== 5'd5 || valid !== 1'b1) begin
            n_err++;
            $display("FAIL held_level: got lows=%0d r=%0d want 1 5", lows, result);
        end
    endtask

    task automatic test_random;
        logic [3:0] a;
        logic [3:0] b;
        for (int i = 0; i < 30; i++) begin
            a = 4'($urandom_range(0, 15));
            b = 4'($urandom_range(0, 15));
            do_sum(a, b, "rand", (i % 3) == 0);
        end
    endtask

    task automatic test_reset_in_conv;
        opA = 4'd15;
        opB = 4'd15;
        somar = 1'b1;
        tick;
        somar = 1'b0;
        tick;
        reset = 1'b1;
        #1;
        n_vec++;
        if (valid !== 1'b0 || result !== 5'd0) begin
            n_err++;
            $display("FAIL conv_reset: got v=%b r=%0d want 0 0", valid, result);
        end
        tick;
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick;
            n_vec++;
            if (valid !== 1'b0 || result !== 5'd0 || seg !== 7'h7F) begin
                n_err++;
                $display("FAIL conv_reset_after: got v=%b r=%0d seg=%h want 0 0 7f",
                         valid, result, seg);
            end
        end
    endtask

    initial begin
        test_reset;
        test_scan;
        test_directed;
        test_ignore_in_conv;
        test_held_level;
        test_random;
        test_reset_in_conv;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
